result_nibble_tx: RTL
=====================

// Module: result_nibble_tx
// PURPOSE
//  Transmit end of the 4-bit operand bus: serialises the two SIZE-bit ECC results (kP.x, kP.y)
//  onto a 4-bit output bus, LSB nibble first. It uses the same nibble order as the input loader:
//  the first nibble carries bits [3:0] and the last carries bits [SIZE-1:SIZE-4].
//  Sits between Control (output_1/output_2/all_done) and the top-level kP[3:0] port.
// PARAMETERS
//  SIZE      32  result width in bits; must be a multiple of NIBBLE_W
//  NIBBLE_W   4  output bus width; NUM_NIB = SIZE/NIBBLE_W (localparam, 8 at default)
// PORTS
//  i_clk      in   1         single clock, rising edge
//  i_rst_n    in   1         asynchronous, active-low reset
//  i_valid    in   1         result pair valid (Control all_done); sampled only while o_ready=1
//  i_x        in   SIZE      result x coordinate (output_1)
//  i_y        in   SIZE      result y coordinate (output_2)
//  i_hold     in   1         sink stall; freezes transmission while high
//  o_ready    out  1         high only in IDLE; block can accept a result pair
//  o_nibble   out  NIBBLE_W  current nibble (kP)
//  o_nib_vld  out  1         o_nibble carries a valid nibble this cycle
//  o_sel      out  1         0 = nibble belongs to x, 1 = nibble belongs to y or checksum
//  o_done     out  1         one-cycle pulse after the last nibble
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, shift regs=0.
//   Outputs under reset: o_ready=1, o_nibble=0, o_nib_vld=0, o_sel=0, o_done=0.
//  FSM: IDLE -> SEND_X -> SEND_Y [-> SEND_CHK] -> DONE -> IDLE.
//  IDLE: when i_valid=1 at edge T, capture i_x and i_y, clear counter and go to SEND_X.
//   The first nibble (i_x[3:0]) is driven with o_nib_vld=1 in cycle T+1.
//  SEND_X: o_nibble = x_sr[3:0], o_sel=0.
//   Each non-held cycle shifts x_sr right by NIBBLE_W and increments the counter.
//   After NUM_NIB nibbles, clear the counter and go to SEND_Y.
//  SEND_Y: same as SEND_X on y_sr with o_sel=1. After NUM_NIB nibbles go to SEND_CHK
//   (macro defined) or DONE.
//  DONE: o_done=1 and o_nib_vld=0 for exactly one cycle, then IDLE. o_ready stays 0 in DONE.
//  Latency: capture to o_done is 2*NUM_NIB+1 cycles (+1 with checksum), plus held cycles.
//  i_hold=1 in a SEND state: state, counter and shift regs are frozen, o_nib_vld=0,
//   o_nibble keeps the pending nibble. i_hold has no effect in IDLE or DONE.
//  i_valid while o_ready=0 is ignored, with no queueing; i_x/i_y changes after capture are ignored.
//  Counter is $clog2(NUM_NIB)+1 bits and compares against NUM_NIB-1; it never wraps mid-word.
//  An i_rst_n assertion mid-transfer aborts immediately to reset values; no o_done is issued.
// CONFIGURATION
//  RESULT_NIB_CHK_EN defined:
//   - Adds state SEND_CHK. After the last y nibble, one extra nibble is sent with o_sel=1.
//   - The extra nibble is the XOR of all 2*NUM_NIB transmitted nibbles, accumulated as each
//     nibble is sent; the accumulator is cleared on capture. SEND_CHK honours i_hold.
//  RESULT_NIB_CHK_EN undefined: no SEND_CHK state and no accumulator; SEND_Y goes to DONE.
// STRUCTURE
//  Shared package ecc_pkg:
//   - SIZE and NIBBLE_W constants.
//   - tx_state_t enum: IDLE, SEND_X, SEND_Y, SEND_CHK, DONE.
//  Sub-module nibble_shreg (load / shift-enable, SIZE wide, NIBBLE_W step), instanced for x and y.
//   The FSM, counter and checksum stay in result_nibble_tx.
// TESTING
//  1. Reset: i_rst_n=0 -> o_ready=1, o_nib_vld=0, o_nibble=0, o_done=0.
//  2. i_x=32'h12345678, i_y=32'h9ABCDEF0, i_valid pulse ->
//     nibbles 8,7,6,5,4,3,2,1 (o_sel=0), then 0,F,E,D,C,B,A,9 (o_sel=1).
//     o_done at cycle T+17 (T+18 with checksum, chk=0).
//  3. RESULT_NIB_CHK_EN, i_x=1, i_y=0 -> 16 data nibbles, then a checksum nibble 1 with o_sel=1,
//     then o_done.
//  4. i_hold=1 for 3 cycles after the 3rd nibble of x (value 6 in case 2) ->
//     o_nib_vld=0 and o_nibble=5 for 3 cycles, then the sequence resumes with 5; o_done is 3 cycles later.
//  5. Second i_valid with different data during SEND_Y -> ignored; the transmitted stream still
//     matches the first pair, and o_ready rises only after o_done.
//  6. i_rst_n pulsed low during SEND_X -> all outputs at reset values, no o_done.
//     A new i_valid afterwards transmits correctly from nibble 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared constants and the transmit FSM state type for the ECC result path.
package ecc_pkg;

   localparam int SIZE     = 32;
   localparam int NIBBLE_W = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SEND_X   = 3'd1,
      SEND_Y   = 3'd2,
      SEND_CHK = 3'd3,
      DONE     = 3'd4
   } tx_state_t;

endpackage

// File: rtl/nibble_shreg.sv
// Nibble-stepped shift register: parallel load, right shift by NIBBLE_W, low nibble exposed.
module nibble_shreg #(
   parameter int SIZE     = ecc_pkg::SIZE,
   parameter int NIBBLE_W = ecc_pkg::NIBBLE_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                shift,
   input  logic [SIZE-1:0]     din,
   output logic [NIBBLE_W-1:0] nib
);

   logic [SIZE-1:0] sr_r;

   // Load wins over shift; zeros fill from the top as nibbles leave.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_r <= '0;
      end else if (load) begin
         sr_r <= din;
      end else if (shift) begin
         sr_r <= sr_r >> NIBBLE_W;
      end else begin
         sr_r <= sr_r;
      end
   end

   assign nib = sr_r[NIBBLE_W-1:0];

endmodule

// File: rtl/result_nibble_tx.sv
// Serialises the kP.x / kP.y result pair onto a nibble bus, LSB nibble first.
// Optional trailing XOR checksum nibble is enabled by defining RESULT_NIB_CHK_EN.
module result_nibble_tx #(
   parameter int SIZE     = ecc_pkg::SIZE,
   parameter int NIBBLE_W = ecc_pkg::NIBBLE_W
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_valid,
   input  logic [SIZE-1:0]     i_x,
   input  logic [SIZE-1:0]     i_y,
   input  logic                i_hold,
   output logic                o_ready,
   output logic [NIBBLE_W-1:0] o_nibble,
   output logic                o_nib_vld,
   output logic                o_sel,
   output logic                o_done
);

   import ecc_pkg::*;

   localparam int NUM_NIB = SIZE / NIBBLE_W;
   localparam int CNT_W   = $clog2(NUM_NIB) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

   tx_state_t           state_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                load_s;
   logic                shift_x_s;
   logic                shift_y_s;
   logic                last_s;
   logic [NIBBLE_W-1:0] x_nib_s;
   logic [NIBBLE_W-1:0] y_nib_s;
`ifdef RESULT_NIB_CHK_EN
   logic [NIBBLE_W-1:0] chk_r;
`endif

   assign load_s    = (state_r == IDLE) && i_valid;
   assign shift_x_s = (state_r == SEND_X) && !i_hold;
   assign shift_y_s = (state_r == SEND_Y) && !i_hold;
   assign last_s    = (cnt_r == LAST_CNT);

   nibble_shreg #(.SIZE(SIZE), .NIBBLE_W(NIBBLE_W)) u_x_sr (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .load  (load_s),
      .shift (shift_x_s),
      .din   (i_x),
      .nib   (x_nib_s)
   );

   nibble_shreg #(.SIZE(SIZE), .NIBBLE_W(NIBBLE_W)) u_y_sr (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .load  (load_s),
      .shift (shift_y_s),
      .din   (i_y),
      .nib   (y_nib_s)
   );

   // Transmit sequencer: word counter, state transitions and checksum accumulation.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
`ifdef RESULT_NIB_CHK_EN
         chk_r   <= '0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (i_valid) begin
                  state_r <= SEND_X;
                  cnt_r   <= '0;
`ifdef RESULT_NIB_CHK_EN
                  chk_r   <= '0;
`endif
               end
            end
            SEND_X: begin
               if (!i_hold) begin
`ifdef RESULT_NIB_CHK_EN
                  chk_r <= chk_r ^ x_nib_s;
`endif
                  if (last_s) begin
                     cnt_r   <= '0;
                     state_r <= SEND_Y;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
            end
            SEND_Y: begin
               if (!i_hold) begin
`ifdef RESULT_NIB_CHK_EN
                  chk_r <= chk_r ^ y_nib_s;
`endif
                  if (last_s) begin
                     cnt_r   <= '0;
`ifdef RESULT_NIB_CHK_EN
                     state_r <= SEND_CHK;
`else
                     state_r <= DONE;
`endif
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
            end
`ifdef RESULT_NIB_CHK_EN
            SEND_CHK: begin
               if (!i_hold) begin
                  state_r <= DONE;
               end
            end
`endif
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   // Output decode from registered state; the hold input only gates the valid strobe.
   always_comb begin
      o_ready   = 1'b0;
      o_nibble  = '0;
      o_nib_vld = 1'b0;
      o_sel     = 1'b0;
      o_done    = 1'b0;
      case (state_r)
         IDLE: begin
            o_ready = 1'b1;
         end
         SEND_X: begin
            o_nibble  = x_nib_s;
            o_nib_vld = !i_hold;
         end
         SEND_Y: begin
            o_nibble  = y_nib_s;
            o_nib_vld = !i_hold;
            o_sel     = 1'b1;
         end
`ifdef RESULT_NIB_CHK_EN
         SEND_CHK: begin
            o_nibble  = chk_r;
            o_nib_vld = !i_hold;
            o_sel     = 1'b1;
         end
`endif
         DONE: begin
            o_done = 1'b1;
         end
         default: begin
            o_ready = 1'b0;
         end
      endcase
   end

endmodule
